// File: rtl/instr_loader_pkg.sv
// Shared types for the boot-time instruction memory loader.
package instr_loader_pkg;

    localparam int LOAD_WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } load_state_t;

endpackage

// File: rtl/le_word_packer.sv
// Packs a byte stream into little-endian 32-bit words; the completed word is
// presented combinationally alongside the fourth byte so the FSM can act on it at once.
import instr_loader_pkg::*;

module le_word_packer (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic [LOAD_WORD_W-1:0] word,
    output logic                   word_valid
);

    logic [1:0]             byte_cnt;
    logic [LOAD_WORD_W-1:0] shift_reg;

    // Newest byte enters at the top, so after four bytes byte0 sits in [7:0].
    assign word       = {byte_data, shift_reg[LOAD_WORD_W-1:8]};
    assign word_valid = byte_valid && (byte_cnt == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else if (clear) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else if (byte_valid) begin
            byte_cnt  <= byte_cnt + 2'd1;
            shift_reg <= word;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Receives a framed program over a byte stream, writes it into instruction memory
// and releases the core from reset only once the checksum matches.
import instr_loader_pkg::*;

module instr_mem_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_WORD = 0,
    parameter int TIMEOUT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int                    CMP_W        = LOAD_WORD_W + 1;
    localparam logic [CMP_W-1:0]      MAX_WORDS    = (CMP_W'(1) << ADDR_W) - CMP_W'(BASE_WORD);
    localparam logic [ADDR_W-1:0]     BASE_ADDR    = ADDR_W'(BASE_WORD);
    localparam logic [ADDR_W:0]       CNT_ONE      = 1;
    localparam logic [31:0]           TIMEOUT_LAST = 32'(TIMEOUT - 1);

    load_state_t            state;
    logic [ADDR_W:0]        word_count;
    logic [31:0]            sum;
    logic [31:0]            idle_cnt;
    logic                   byte_fire;
    logic                   load_start;
    logic                   collecting;
    logic                   timed_out;
    logic [LOAD_WORD_W-1:0] pk_word;
    logic                   pk_valid;

    assign byte_fire  = s_valid && s_ready;
    assign load_start = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign collecting = (state == HDR) || (state == DATA) || (state == CSUM);
    assign timed_out  = (TIMEOUT != 0) && collecting && !byte_fire && (idle_cnt == TIMEOUT_LAST);
    assign mem_we     = mem_req;
    assign mem_be     = 4'hF;

    le_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_start),
        .byte_valid (byte_fire),
        .byte_data  (s_data),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    // The same packer feeds header, data and checksum; the state decides what a word means.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            s_ready      <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            core_rst_n   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            word_count   <= '0;
            sum          <= '0;
            idle_cnt     <= '0;
        end else begin
            if (collecting && !byte_fire) begin
                idle_cnt <= idle_cnt + 32'd1;
            end else begin
                idle_cnt <= '0;
            end

            case (state)
                IDLE, DONE, ERR: begin
                    if (state == DONE) begin
                        core_rst_n <= 1'b1;
                    end
                    if (load_start) begin
                        state        <= HDR;
                        s_ready      <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        core_rst_n   <= 1'b0;
                        words_loaded <= '0;
                        sum          <= '0;
                        mem_addr     <= BASE_ADDR;
                    end
                end
                HDR: begin
                    if (timed_out) begin
                        state   <= ERR;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        error   <= 1'b1;
                    end else if (pk_valid) begin
                        word_count <= pk_word[ADDR_W:0];
                        if (pk_word == '0) begin
                            state <= CSUM;
                        end else if ({1'b0, pk_word} > MAX_WORDS) begin
                            state   <= ERR;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            error   <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (timed_out) begin
                        state   <= ERR;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        error   <= 1'b1;
                    end else if (pk_valid) begin
                        state     <= WRITE;
                        s_ready   <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_wdata <= pk_word;
                    end
                end
                // Address and data stay frozen here until the memory grants.
                WRITE: begin
                    if (mem_gnt) begin
                        mem_req      <= 1'b0;
                        s_ready      <= 1'b1;
                        mem_addr     <= mem_addr + ADDR_W'(1);
                        words_loaded <= words_loaded + CNT_ONE;
                        sum          <= sum + mem_wdata;
                        state        <= ((words_loaded + CNT_ONE) == word_count) ? CSUM : DATA;
                    end
                end
                CSUM: begin
                    if (timed_out) begin
                        state   <= ERR;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        error   <= 1'b1;
                    end else if (pk_valid) begin
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        if (pk_word == sum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
